// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types and sizes for the Tomasulo reorder buffer and its users.
//   ROB_ADDR_LEN : width of a ROB tag (entry count is 2**ROB_ADDR_LEN)
//   REG_ADDR_LEN : width of an architectural register address
//   DEFAULT_XLEN : default result width
//   ROB_ENTRY    : per-entry bookkeeping (the result value is kept beside it)
// Optional feature macro: ROB_MISPREDICT_EN adds the mispredict field.
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_ADDR_LEN = 3;
  localparam int REG_ADDR_LEN = 5;
  localparam int DEFAULT_XLEN = 32;

  // The result value is stored in a separate array so that the entry layout
  // does not depend on the XLEN parameter of a particular instance.
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    hasDest;
    logic [REG_ADDR_LEN-1:0] destReg;
`ifdef ROB_MISPREDICT_EN
    logic                    mispredict;
`endif
  } ROB_ENTRY;

endpackage

// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
// Bundles the reorder buffer's dispatch, CDB, operand-query, rename (map
// table) and commit signals.
//   master : dispatch unit / CDB / map table side (drives dispatch, CDB, query)
//   slave  : the reorder buffer itself
// Signals:
//   dispatch_valid/has_dest/dest_reg -> ROB ; dispatch_ready <- ROB
//   assign_flag/assign_rob_tag <- ROB (allocation, to map table and RS)
//   cdb_valid/rob_tag/value/mispredict -> ROB (completion broadcast)
//   query_tag[2] -> ROB ; query_ready[2]/query_value[2] <- ROB
//   return_flag/reg_addr_from_rob/return_rob_tag/commit_value <- ROB (commit)
//   flush <- ROB (squash of speculative state)
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
  parameter int XLEN = reorder_buffer_pkg::DEFAULT_XLEN
);
  import reorder_buffer_pkg::*;

  logic                    dispatch_valid;
  logic                    dispatch_has_dest;
  logic [REG_ADDR_LEN-1:0] dispatch_dest_reg;
  logic                    dispatch_ready;
  logic                    assign_flag;
  logic [ROB_ADDR_LEN-1:0] assign_rob_tag;

  logic                    cdb_valid;
  logic [ROB_ADDR_LEN-1:0] cdb_rob_tag;
  logic [XLEN-1:0]         cdb_value;
  logic                    cdb_mispredict;

  logic [ROB_ADDR_LEN-1:0] query_tag   [2];
  logic                    query_ready [2];
  logic [XLEN-1:0]         query_value [2];

  logic                    return_flag;
  logic [REG_ADDR_LEN-1:0] reg_addr_from_rob;
  logic [ROB_ADDR_LEN-1:0] return_rob_tag;
  logic [XLEN-1:0]         commit_value;
  logic                    flush;

  modport master (
    output dispatch_valid, dispatch_has_dest, dispatch_dest_reg,
    output cdb_valid, cdb_rob_tag, cdb_value, cdb_mispredict,
    output query_tag,
    input  dispatch_ready, assign_flag, assign_rob_tag,
    input  query_ready, query_value,
    input  return_flag, reg_addr_from_rob, return_rob_tag, commit_value, flush
  );

  modport slave (
    input  dispatch_valid, dispatch_has_dest, dispatch_dest_reg,
    input  cdb_valid, cdb_rob_tag, cdb_value, cdb_mispredict,
    input  query_tag,
    output dispatch_ready, assign_flag, assign_rob_tag,
    output query_ready, query_value,
    output return_flag, reg_addr_from_rob, return_rob_tag, commit_value, flush
  );

endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer for the Tomasulo core. Allocates tags at dispatch,
// captures CDB results, retires one instruction per cycle in program order,
// and serves completed-but-uncommitted results to dispatch for operand read.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : reorder_buffer_if.slave (dispatch, CDB, query, rename, commit)
// Parameters:
//   ROB_SIZE : entry count, must equal 2**ROB_ADDR_LEN
//   XLEN     : result width
// Optional feature macro: ROB_MISPREDICT_EN
//   defined   -> a mispredicted branch reaching commit raises flush and
//                squashes every younger entry
//   undefined -> cdb_mispredict is ignored and flush is tied low
// ---------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = 1 << ROB_ADDR_LEN,
  parameter int XLEN     = DEFAULT_XLEN
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave bus
);

  localparam int CNT_W = ROB_ADDR_LEN + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ROB_SIZE);

  ROB_ENTRY                r_entry [ROB_SIZE];
  logic [XLEN-1:0]         r_value [ROB_SIZE];
  logic [ROB_ADDR_LEN-1:0] r_head;
  logic [ROB_ADDR_LEN-1:0] r_tail;
  logic [CNT_W-1:0]        r_count;

  ROB_ENTRY                w_entryNext [ROB_SIZE];
  logic [XLEN-1:0]         w_valueNext [ROB_SIZE];
  logic [ROB_ADDR_LEN-1:0] w_headNext;
  logic [ROB_ADDR_LEN-1:0] w_tailNext;
  logic [CNT_W-1:0]        w_countNext;

  ROB_ENTRY w_headEntry;
  logic     w_commit;
  logic     w_flush;
  logic     w_dispatch;

  // The head retires once its result has been captured. Commit is held off
  // during reset so nothing in flight leaks out to the map table.
  assign w_headEntry = r_entry[r_head];
  assign w_commit    = w_headEntry.valid & w_headEntry.done & ~reset;

`ifdef ROB_MISPREDICT_EN
  // A mispredicted branch at commit squashes everything younger than it.
  assign w_flush = w_commit & w_headEntry.mispredict;
`else
  logic w_unusedMispredict;
  assign w_unusedMispredict = bus.cdb_mispredict;
  assign w_flush = 1'b0;
`endif

  // Allocation depends only on registered occupancy, so a full buffer does
  // not accept in the same cycle it frees an entry.
  assign bus.dispatch_ready = (r_count != FULL_COUNT) & ~w_flush;
  assign w_dispatch         = bus.dispatch_valid & bus.dispatch_ready & ~reset;
  assign bus.assign_flag    = w_dispatch & bus.dispatch_has_dest;
  assign bus.assign_rob_tag = r_tail;

  // Commit-side rename and register-file write information comes straight
  // from the head entry.
  assign bus.return_flag       = w_commit & w_headEntry.hasDest;
  assign bus.reg_addr_from_rob = w_headEntry.destReg;
  assign bus.return_rob_tag    = r_head;
  assign bus.commit_value      = r_value[r_head];
  assign bus.flush             = w_flush;

  // Operand lookups see registered state only; a result on the CDB this
  // cycle reaches the reservation stations through their own snoop.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      bus.query_ready[q] = r_entry[bus.query_tag[q]].valid &
                           r_entry[bus.query_tag[q]].done;
      bus.query_value[q] = r_value[bus.query_tag[q]];
    end
  end

  // Next-state: CDB capture, then retirement of the head, then either the
  // squash on a mispredict or allocation at the tail. Occupancy moves by
  // (+dispatch - commit) so all three can coexist in one cycle.
  always_comb begin
    w_entryNext = r_entry;
    w_valueNext = r_value;
    w_headNext  = r_head;
    w_tailNext  = r_tail;
    w_countNext = r_count;

    if (bus.cdb_valid && r_entry[bus.cdb_rob_tag].valid && !w_flush) begin
      w_entryNext[bus.cdb_rob_tag].done = 1'b1;
      w_valueNext[bus.cdb_rob_tag]      = bus.cdb_value;
`ifdef ROB_MISPREDICT_EN
      w_entryNext[bus.cdb_rob_tag].mispredict = bus.cdb_mispredict;
`endif
    end

    if (w_commit) begin
      w_entryNext[r_head] = '0;
      w_valueNext[r_head] = '0;
      w_headNext          = r_head + 1'b1;
    end

    if (w_flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        w_entryNext[i] = '0;
        w_valueNext[i] = '0;
      end
      w_tailNext  = r_head + 1'b1;
      w_countNext = '0;
    end else begin
      if (w_dispatch) begin
        w_entryNext[r_tail]         = '0;
        w_entryNext[r_tail].valid   = 1'b1;
        w_entryNext[r_tail].hasDest = bus.dispatch_has_dest;
        w_entryNext[r_tail].destReg = bus.dispatch_dest_reg;
        w_valueNext[r_tail]         = '0;
        w_tailNext                  = r_tail + 1'b1;
      end
      w_countNext = r_count + CNT_W'(w_dispatch) - CNT_W'(w_commit);
    end
  end

  // State register. Reset empties the buffer and wins over any activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_entry[i] <= '0;
        r_value[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_entry <= w_entryNext;
      r_value <= w_valueNext;
      r_head  <= w_headNext;
      r_tail  <= w_tailNext;
      r_count <= w_countNext;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
// Self-checking bench for reorder_buffer. A queue-based reference model
// tracks in-flight instructions in program order; commits with a destination
// are pushed to a scoreboard at dispatch and popped by an independent monitor
// whenever return_flag is seen.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int N = 1 << ROB_ADDR_LEN;

  typedef struct {
    int tag;
    int dreg;
  } sbEntry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int nChecks = 0;
  int nFails  = 0;

  sbEntry_t        sb[$];
  int              infl[$];
  bit              mValid   [N];
  bit              mDone    [N];
  bit              mMis     [N];
  bit              mHasDest [N];
  logic [31:0]     mValue   [N];
  int              mTail;

  always #5 clk = ~clk;

  reorder_buffer_if #(.XLEN(DEFAULT_XLEN)) bus ();

  reorder_buffer #(.ROB_SIZE(N), .XLEN(DEFAULT_XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < N; i++) begin
      mValid[i] = 0; mDone[i] = 0; mMis[i] = 0; mHasDest[i] = 0; mValue[i] = '0;
    end
    infl.delete();
    sb.delete();
    mTail = 0;
  endtask

  task automatic driveIdle();
    bus.dispatch_valid    = 1'b0;
    bus.dispatch_has_dest = 1'b0;
    bus.dispatch_dest_reg = '0;
    bus.cdb_valid         = 1'b0;
    bus.cdb_rob_tag       = '0;
    bus.cdb_value         = '0;
    bus.cdb_mispredict    = 1'b0;
    bus.query_tag[0]      = '0;
    bus.query_tag[1]      = '0;
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    driveIdle();
    repeat (cycles) @(posedge clk);
    #1;
    modelClear();
    reset = 1'b0;
  endtask

  // One cycle of stimulus: drive, check combinational outputs against the
  // model, advance the model by this cycle's events, then clock.
  task automatic applyStimulus(input bit dv, input bit hasDest, input int dreg,
                               input bit cv, input int ctag, input logic [31:0] cval,
                               input bit cmis, input int q0, input int q1);
    bit expCommit, expFlush, expReady, acc;
    int h;
    h = 0;
    bus.dispatch_valid    = dv;
    bus.dispatch_has_dest = hasDest;
    bus.dispatch_dest_reg = 5'(dreg);
    bus.cdb_valid         = cv;
    bus.cdb_rob_tag       = 3'(ctag);
    bus.cdb_value         = cval;
    bus.cdb_mispredict    = cmis;
    bus.query_tag[0]      = 3'(q0);
    bus.query_tag[1]      = 3'(q1);
    #1;
    expCommit = (infl.size() > 0) && mDone[infl[0]];
`ifdef ROB_MISPREDICT_EN
    expFlush = expCommit && mMis[infl[0]];
`else
    expFlush = 1'b0;
`endif
    expReady = (infl.size() < N) && !expFlush;
    acc      = dv && expReady;
    checkOutput("dispatch_ready", 64'(bus.dispatch_ready), 64'(expReady));
    checkOutput("assign_rob_tag", 64'(bus.assign_rob_tag), 64'(mTail));
    checkOutput("assign_flag", 64'(bus.assign_flag), 64'(acc && hasDest));
    checkOutput("flush", 64'(bus.flush), 64'(expFlush));
    checkOutput("query_ready0", 64'(bus.query_ready[0]), 64'(mValid[q0] && mDone[q0]));
    checkOutput("query_ready1", 64'(bus.query_ready[1]), 64'(mValid[q1] && mDone[q1]));
    if (mValid[q0] && mDone[q0])
      checkOutput("query_value0", 64'(bus.query_value[0]), 64'(mValue[q0]));
    if (mValid[q1] && mDone[q1])
      checkOutput("query_value1", 64'(bus.query_value[1]), 64'(mValue[q1]));

    if (cv && mValid[ctag] && !expFlush) begin
      mDone[ctag]  = 1;
      mValue[ctag] = cval;
      mMis[ctag]   = cmis;
    end
    if (expCommit) begin
      h = infl.pop_front();
      mValid[h] = 0; mDone[h] = 0; mMis[h] = 0;
    end
    if (expFlush) begin
      for (int i = 0; i < N; i++) begin
        mValid[i] = 0; mDone[i] = 0; mMis[i] = 0;
      end
      infl.delete();
      // Only the branch's own rename return (if any) is still to be seen.
      while (sb.size() > (mHasDest[h] ? 1 : 0)) void'(sb.pop_back());
      mTail = (h + 1) % N;
    end else if (acc) begin
      mValid[mTail]   = 1;
      mDone[mTail]    = 0;
      mMis[mTail]     = 0;
      mHasDest[mTail] = hasDest;
      infl.push_back(mTail);
      if (hasDest) sb.push_back('{tag: mTail, dreg: dreg});
      mTail = (mTail + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  // Complete outstanding entries (youngest not-done first) until empty.
  task automatic drain();
    int guard;
    int t;
    bit c;
    guard = 0;
    while (infl.size() > 0 && guard < 200) begin
      c = 0; t = 0;
      foreach (infl[i]) if (!mDone[infl[i]]) begin t = infl[i]; c = 1; end
      applyStimulus(0, 0, 0, c, t, $urandom, 0, $urandom_range(0, N-1), $urandom_range(0, N-1));
      guard++;
    end
    if (infl.size() > 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain timeout: %0d entries in flight, expected 0", infl.size());
    end
  endtask

  // Monitor: pops the scoreboard on every rename return the DUT presents.
  initial begin : monitor
    sbEntry_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("return_flag in reset", 64'(bus.return_flag), 64'(0));
      end else if (bus.return_flag) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected return_flag: tag %0d, expected no commit", bus.return_rob_tag);
        end else begin
          e = sb.pop_front();
          checkOutput("return_rob_tag", 64'(bus.return_rob_tag), 64'(e.tag));
          checkOutput("reg_addr_from_rob", 64'(bus.reg_addr_from_rob), 64'(e.dreg));
          checkOutput("commit_value", 64'(bus.commit_value), 64'(mValue[e.tag]));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r, t, idx;
    bit cv;
    modelClear();
    applyReset(2);

    // Reset state
    checkOutput("reset dispatch_ready", 64'(bus.dispatch_ready), 64'(1));
    checkOutput("reset assign_rob_tag", 64'(bus.assign_rob_tag), 64'(0));
    checkOutput("reset assign_flag", 64'(bus.assign_flag), 64'(0));
    checkOutput("reset return_flag", 64'(bus.return_flag), 64'(0));
    checkOutput("reset flush", 64'(bus.flush), 64'(0));
    checkOutput("reset query_ready0", 64'(bus.query_ready[0]), 64'(0));
    checkOutput("reset commit_value", 64'(bus.commit_value), 64'(0));
    checkOutput("reset reg_addr_from_rob", 64'(bus.reg_addr_from_rob), 64'(0));
    checkOutput("reset return_rob_tag", 64'(bus.return_rob_tag), 64'(0));

    // Fill with r1..r8, then a 9th request that must be refused
    for (int i = 0; i < N; i++) applyStimulus(1, 1, i + 1, 0, 0, 0, 0, i, 0);
    applyStimulus(1, 1, 9, 1, 2, 32'h22, 0, 2, 0);
    applyStimulus(1, 1, 9, 1, 1, 32'h11, 0, 2, 1);
    applyStimulus(1, 1, 9, 1, 0, 32'h10, 0, 0, 1);
    // Head done while full: commit of tag 0, then wrap allocation of tag 0
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, i, 7);
    drain();

    // Query of a completed entry and of an incomplete one
    applyReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, i + 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 32'hABCD, 0, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 1);
    drain();

`ifdef ROB_MISPREDICT_EN
    // Mispredicted branch at tag 1 with five entries in flight
    applyReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, i + 10, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h6, 1, 0, 0);
    applyStimulus(1, 1, 20, 0, 0, 0, 0, 1, 2);
    checkOutput("post-flush assign_rob_tag", 64'(bus.assign_rob_tag), 64'(2));
    checkOutput("post-flush dispatch_ready", 64'(bus.dispatch_ready), 64'(1));
`endif

    // Randomized traffic with one reset in the middle
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) applyReset(1);
      cv = 0; t = 0;
      r = $urandom_range(0, 3);
      if (r < 2 && infl.size() > 0) begin
        idx = $urandom_range(0, infl.size() - 1);
        t = infl[idx];
        cv = !mDone[t];
      end else if (r == 2) begin
        t = $urandom_range(0, N - 1);
        cv = !mValid[t];
      end
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                    cv, t, $urandom, $urandom_range(0, 7) == 0,
                    $urandom_range(0, N - 1), $urandom_range(0, N - 1));
    end
    drain();
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("scoreboard empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo core: allocates ROB tags to dispatching instructions and captures results from the CDB. It retires instructions in program order, one per cycle. It is the producer side of the map table's rename interface: it issues `assign_flag`/`assign_rob_tag` on dispatch and `return_flag`/`reg_addr_from_rob`/`return_rob_tag` on commit. It also serves uncommitted results to dispatch for operand read.

## Interface
Parameters
- `ROB_SIZE`, default 8: entry count; must equal 2**`` `ROB_ADDR_LEN ``.
- `XLEN`, default 32: result width.

Ports
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `dispatch_valid` in 1: instruction presented for allocation.
- `dispatch_has_dest` in 1: instruction writes an architectural register.
- `dispatch_dest_reg` in `` `REG_ADDR_LEN ``: destination register.
- `dispatch_ready` out 1: entry available; allocation happens when `dispatch_valid & dispatch_ready`.
- `assign_flag` out 1: allocation with destination this cycle (to map table).
- `assign_rob_tag` out `` `ROB_ADDR_LEN ``: tag at tail (to map table / RS).
- `cdb_valid` in 1: CDB broadcast.
- `cdb_rob_tag` in `` `ROB_ADDR_LEN ``: completing entry.
- `cdb_value` in XLEN: result.
- `cdb_mispredict` in 1: completing branch was mispredicted.
- `query_tag[2]` in `` `ROB_ADDR_LEN `` each: operand lookups.
- `query_ready[2]` out 1 each: entry is done.
- `query_value[2]` out XLEN each: stored result.
- `return_flag` out 1: commit of an entry with destination (to map table).
- `reg_addr_from_rob` out `` `REG_ADDR_LEN ``: committing destination.
- `return_rob_tag` out `` `ROB_ADDR_LEN ``: committing tag.
- `commit_value` out XLEN: value for register file write.
- `flush` out 1: squash all speculative state.

## Operation
- Entry fields: `valid`, `done`, `has_dest`, `dest_reg`, `value`, `mispredict`. Pointers `head` and `tail` are `` `ROB_ADDR_LEN `` bits and wrap naturally. Occupancy `count` is `` `ROB_ADDR_LEN ``+1 bits.
- **Dispatch:**
  - `dispatch_ready = (count != ROB_SIZE) & ~flush`.
  - On accept, write the entry at `tail` with `done=0` and `mispredict=0`, then increment `tail`.
  - `assign_flag = dispatch_valid & dispatch_ready & dispatch_has_dest`.
- **Complete:** on `cdb_valid`, set `done=1` and latch `value` and `mispredict` into entry `cdb_rob_tag`. A CDB write to an invalid entry is ignored.
- **Commit:**
  - The head commits when `valid[head] & done[head]`.
  - On commit, clear the entry and increment `head`.
  - `return_flag = commit & has_dest[head]`.
  - `reg_addr_from_rob`, `return_rob_tag` (= `head`) and `commit_value` are driven combinationally from the head entry.
- **Simultaneous events:** dispatch, CDB write and commit may all happen in one cycle. In that case `count` changes by (+dispatch − commit). `dispatch_ready` is computed from the registered `count`, so a full ROB does not accept in the cycle it commits.
- **Query:**
  - `query_ready = valid[t] & done[t]`, read combinationally from registered state. There is no same-cycle CDB bypass; the CDB is forwarded to the RS separately.
  - `query_value = value[t]`.
- **Flush:** described under Configuration.

## Timing
- **Reset** (synchronous, priority over all activity):
  - All entries invalid; `head = tail = count = 0`.
  - Outputs: `dispatch_ready=1`, `assign_rob_tag=0`; `assign_flag`, `return_flag`, `flush`, `query_ready` = 0; `commit_value`, `reg_addr_from_rob`, `return_rob_tag` = 0.
- **Reset mid-operation:** all in-flight entries are discarded, with no commit in the reset cycle.
- **CDB-to-commit latency:** minimum 1 cycle. A completion written in cycle N commits in N+1 at earliest.
- **Dispatch-to-commit:** minimum 2 cycles (dispatch N, CDB N+1, commit N+2).
- **Commit bandwidth:** at most one commit per cycle.
- **Empty:** `head == tail` and `count == 0`; no commit.
- **Full:** `count == ROB_SIZE`, `head == tail`; `dispatch_ready=0`.

## Configuration
Macro `` `ROB_MISPREDICT_EN ``.

With `` `ROB_MISPREDICT_EN `` defined:
- When the head commits with `mispredict=1`, `flush=1` in that cycle.
- The branch's own `return_flag` still fires.
- Dispatch is blocked in that cycle.
- Next cycle: all entries are invalid, `tail = head+1`, `count = 0`.
- A CDB write in the flush cycle is dropped.

Without `` `ROB_MISPREDICT_EN ``:
- `cdb_mispredict` is ignored.
- `flush` is tied to 0.
- The `mispredict` field is not instantiated.

## Structure
- `ROB_ENTRY` struct goes in a shared `rob.svh` header alongside the existing map-table typedefs.
- `` `ROB_ADDR_LEN ``, `` `REG_ADDR_LEN `` and `XLEN` come from the shared headers.
- There are no sub-modules: entry array, pointers and count live in one module with a single `always_ff` plus a combinational next-state block.

## Test plan
- **Reset, fill and full:**
  - Stimulus: after reset, dispatch 8 instructions with destinations r1–r8.
  - Expected during the fill: `assign_rob_tag` takes values 0..7 and `assign_flag` goes high each cycle.
  - Expected at the 9th request: `dispatch_ready=0`.
- **In-order commit:**
  - Stimulus: CDB completes tag 2 (value 0x22), then tags 1 and 0.
  - Expected: no commit until tag 0 is done, then commits of tags 0, 1, 2 on consecutive cycles.
  - Expected outputs: `return_rob_tag` 0, 1, 2 and `commit_value` 0x22 on the third commit.
- **Full plus commit:**
  - Stimulus: with the ROB full and the head done, hold `dispatch_valid`.
  - Expected: commit of tag 0 in cycle N; dispatch accepted in N+1 with `assign_rob_tag=0` (wrap).
- **No-destination entry:**
  - Stimulus: dispatch with `dispatch_has_dest=0`, complete it.
  - Expected: `assign_flag=0`; at commit `return_flag=0` while `head` still advances.
- **Query:**
  - Stimulus: CDB completes tag 3 with 0xABCD.
  - Expected: next cycle `query_tag[0]=3` gives `query_ready=1`, `query_value=0xABCD`; an incomplete tag gives `query_ready=0`.
- **Mispredict (`` `ROB_MISPREDICT_EN ``):**
  - Stimulus: 5 entries in flight; tag 1 completes with `cdb_mispredict=1`.
  - Expected: `flush=1` in tag 1's commit cycle; next cycle `count=0` and `assign_rob_tag=2`.
